// File: rtl/seq_mult_pkg.sv
// Shared types and limits for the seq_mult radix-2 sequential multiplier.
package seq_mult_pkg;

    localparam int MAX_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } seq_mult_state_t;

endpackage

// File: rtl/mult_step.sv
// One shift-add iteration: extends the accumulator high half and the multiplicand
// to W+1 bits, then adds or subtracts the partial product selected by the multiplier bit.
module mult_step
    import seq_mult_pkg::*;
#(
    parameter int W = 8
) (
    input  logic [W-1:0] acc_hi,
    input  logic [W-1:0] a_r,
    input  logic         b_bit,
    input  logic         sub,
    input  logic         sm,
    output logic [W:0]   sum
);

    logic [W:0] ext_hi;
    logic [W:0] ext_a;
    logic [W:0] pp;

    always_comb begin
        ext_hi = {sm & acc_hi[W-1], acc_hi};
        ext_a  = {sm & a_r[W-1], a_r};
        pp     = b_bit ? ext_a : '0;
        // The multiplier MSB carries negative weight in signed mode.
        sum    = sub ? (ext_hi - pp) : (ext_hi + pp);
    end

endmodule

// File: rtl/seq_mult.sv
// Radix-2 sequential shift-add multiplier, W x W -> 2W in W iterations, with
// optional two's-complement mode, busy/ready handshake and a held product register.
module seq_mult
    import seq_mult_pkg::*;
#(
    parameter  int W  = 8,
    localparam int CW = $clog2(W)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic           signed_mode,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic           busy,
    output logic           ready,
    output logic [2*W-1:0] m
);

    if (W < 2 || W > MAX_W) begin : g_bad_width
        $error("seq_mult: W must lie in 2..%0d", MAX_W);
    end

    localparam logic [CW-1:0] LAST = CW'(W - 1);

    seq_mult_state_t state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [W-1:0]    a_q, a_d;
    logic [W-1:0]    b_q, b_d;
    logic            sm_q, sm_d;
    logic [W-1:0]    hi_q, hi_d;
    logic [W-1:0]    lo_q, lo_d;
    logic [2*W-1:0]  m_q, m_d;
    logic            take;
    logic            sub;
    logic [W:0]      sum;

    assign sub = sm_q & (cnt_q == LAST);

    mult_step #(.W(W)) u_step (
        .acc_hi (hi_q),
        .a_r    (a_q),
        .b_bit  (b_q[0]),
        .sub    (sub),
        .sm     (sm_q),
        .sum    (sum)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sm_q    <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            m_q     <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sm_q    <= sm_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            m_q     <= m_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        sm_d    = sm_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        m_d     = m_q;
        take    = 1'b0;

        case (state_q)
            IDLE: begin
                take = start;
            end
            RUN: begin
                hi_d  = sum[W:1];
                lo_d  = {sum[0], lo_q[W-1:1]};
                b_d   = b_q >> 1;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    m_d     = {hi_d, lo_d};
                    state_d = DONE;
                end
            end
            DONE: begin
                take    = start;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Accepting a request is identical from IDLE and DONE, so it overrides both.
        if (take) begin
            a_d     = a;
            b_d     = b;
            sm_d    = signed_mode;
            hi_d    = '0;
            lo_d    = '0;
            cnt_d   = '0;
            state_d = RUN;
        end
    end

    assign busy  = (state_q == RUN);
    assign ready = (state_q == DONE);
    assign m     = m_q;

endmodule

// File: tb/tb_seq_mult.sv
// Scoreboard bench for seq_mult at W = 8, 16 and 2 against an arithmetic product model.
module tb_seq_mult;

    typedef struct {
        logic [63:0] m;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic        rst8, st8, sm8, busy8, ready8;
    logic [7:0]  a8, b8;
    logic [15:0] m8;
    logic        rst16, st16, sm16, busy16, ready16;
    logic [15:0] a16, b16;
    logic [31:0] m16;
    logic        rst2, st2, sm2, busy2, ready2;
    logic [1:0]  a2, b2;
    logic [3:0]  m2;

    seq_mult #(.W(8)) dut8 (
        .clk(clk), .rst_n(rst8), .start(st8), .signed_mode(sm8), .a(a8), .b(b8),
        .busy(busy8), .ready(ready8), .m(m8)
    );
    seq_mult #(.W(16)) dut16 (
        .clk(clk), .rst_n(rst16), .start(st16), .signed_mode(sm16), .a(a16), .b(b16),
        .busy(busy16), .ready(ready16), .m(m16)
    );
    seq_mult #(.W(2)) dut2 (
        .clk(clk), .rst_n(rst2), .start(st2), .signed_mode(sm2), .a(a2), .b(b2),
        .busy(busy2), .ready(ready2), .m(m2)
    );

    exp_t q8[$], q16[$], q2[$];
    exp_t e8, e16, e2;
    logic [15:0] last8;
    logic [31:0] last16;
    logic [3:0]  last2;
    int run8, run16, run2;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: interpret operands by mode, multiply as integers, keep 2W bits.
    function automatic logic [63:0] ref_mul(input int w, input logic [31:0] av,
                                            input logic [31:0] bv, input logic smv);
        longint      sa, sb;
        logic [63:0] mask;
        mask = (64'd1 << w) - 64'd1;
        sa = longint'(av & mask[31:0]);
        sb = longint'(bv & mask[31:0]);
        if (smv) begin
            if (sa >= (longint'(1) << (w - 1))) sa -= longint'(1) << w;
            if (sb >= (longint'(1) << (w - 1))) sb -= longint'(1) << w;
        end
        return 64'(sa * sb) & ((64'd1 << (2 * w)) - 64'd1);
    endfunction

    function automatic int wid(input int which);
        return (which == 0) ? 8 : (which == 1) ? 16 : 2;
    endfunction

    function automatic logic [31:0] pick(input int w);
        logic [31:0] mask;
        mask = (32'd1 << w) - 32'd1;
        case ($urandom_range(0, 5))
            0:       return '0;
            1:       return mask;
            2:       return 32'd1 << (w - 1);
            3:       return (32'd1 << (w - 1)) - 32'd1;
            default: return $urandom & mask;
        endcase
    endfunction

    task automatic drive(input int which, input logic s, input logic [31:0] av,
                         input logic [31:0] bv, input logic smv);
        case (which)
            0:       begin st8  = s; a8  = av[7:0];  b8  = bv[7:0];  sm8  = smv; end
            1:       begin st16 = s; a16 = av[15:0]; b16 = bv[15:0]; sm16 = smv; end
            default: begin st2  = s; a2  = av[1:0];  b2  = bv[1:0];  sm2  = smv; end
        endcase
    endtask

    // Called at a negedge in IDLE or DONE; returns at the negedge of the DONE cycle.
    task automatic op(input int which, input logic [31:0] av, input logic [31:0] bv,
                      input logic smv, input bit noise);
        int   w;
        exp_t e;
        w = wid(which);
        drive(which, 1'b1, av, bv, smv);
        e.m   = ref_mul(w, av, bv, smv);
        e.cyc = cyc + 1 + w;
        case (which)
            0:       q8.push_back(e);
            1:       q16.push_back(e);
            default: q2.push_back(e);
        endcase
        for (int i = 0; i < w; i++) begin
            @(negedge clk);
            if (noise)
                drive(which, 1'($urandom_range(0, 1)), $urandom, $urandom,
                      1'($urandom_range(0, 1)));
            else
                drive(which, 1'b0, av, bv, smv);
        end
        @(negedge clk);
        drive(which, 1'b0, av, bv, smv);
    endtask

    always @(negedge clk) begin
        if (!rst8) begin
            last8 = '0;
            run8  = 0;
        end else begin
            if (busy8) run8++;
            if (ready8) begin
                if (q8.size() == 0) chk("w8 spurious ready", 64'(q8.size()), 64'd1);
                else begin
                    e8 = q8.pop_front();
                    chk("w8 product", 64'(m8), e8.m);
                    chk("w8 ready latency", 64'(cyc), 64'(e8.cyc));
                    chk("w8 busy cycles", 64'(run8), 64'd8);
                end
                run8  = 0;
                last8 = m8;
            end else chk("w8 m held", 64'(m8), 64'(last8));
        end
    end

    always @(negedge clk) begin
        if (!rst16) begin
            last16 = '0;
            run16  = 0;
        end else begin
            if (busy16) run16++;
            if (ready16) begin
                if (q16.size() == 0) chk("w16 spurious ready", 64'(q16.size()), 64'd1);
                else begin
                    e16 = q16.pop_front();
                    chk("w16 product", 64'(m16), e16.m);
                    chk("w16 ready latency", 64'(cyc), 64'(e16.cyc));
                    chk("w16 busy cycles", 64'(run16), 64'd16);
                end
                run16  = 0;
                last16 = m16;
            end else chk("w16 m held", 64'(m16), 64'(last16));
        end
    end

    always @(negedge clk) begin
        if (!rst2) begin
            last2 = '0;
            run2  = 0;
        end else begin
            if (busy2) run2++;
            if (ready2) begin
                if (q2.size() == 0) chk("w2 spurious ready", 64'(q2.size()), 64'd1);
                else begin
                    e2 = q2.pop_front();
                    chk("w2 product", 64'(m2), e2.m);
                    chk("w2 ready latency", 64'(cyc), 64'(e2.cyc));
                    chk("w2 busy cycles", 64'(run2), 64'd2);
                end
                run2  = 0;
                last2 = m2;
            end else chk("w2 m held", 64'(m2), 64'(last2));
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", tests, fails);
        $fatal(1, "watchdog");
    end

    initial begin
        rst8 = 1'b0; rst16 = 1'b0; rst2 = 1'b0;
        for (int k = 0; k < 3; k++) drive(k, 1'b0, '0, '0, 1'b0);
        repeat (3) @(negedge clk);
        chk("reset busy w8", 64'(busy8), 64'd0);
        chk("reset ready w8", 64'(ready8), 64'd0);
        chk("reset m w8", 64'(m8), 64'd0);
        chk("reset busy w16", 64'(busy16), 64'd0);
        chk("reset m w16", 64'(m16), 64'd0);
        chk("reset busy w2", 64'(busy2), 64'd0);
        chk("reset m w2", 64'(m2), 64'd0);
        rst8 = 1'b1; rst16 = 1'b1; rst2 = 1'b1;
        @(negedge clk);

        fork
            begin
                op(0, 13, 11, 1'b0, 1'b0);
                @(negedge clk);
                op(0, 255, 255, 1'b0, 1'b0);
                op(0, 0, 255, 1'b0, 1'b0);
                @(negedge clk);
                op(0, 'hFD, 5, 1'b1, 1'b0);
                op(0, 'h80, 'h80, 1'b1, 1'b0);
                op(0, 'h7F, 'hFF, 1'b1, 1'b0);
                @(negedge clk);
                op(0, 13, 11, 1'b0, 1'b0);
                op(0, 7, 6, 1'b0, 1'b1);
                @(negedge clk);
                // Abort an operation with an asynchronous reset between edges.
                drive(0, 1'b1, 'h5A, 'hC3, 1'b1);
                @(negedge clk);
                drive(0, 1'b0, '0, '0, 1'b0);
                repeat (3) @(negedge clk);
                @(posedge clk);
                #2 rst8 = 1'b0;
                #1;
                chk("async reset busy", 64'(busy8), 64'd0);
                chk("async reset ready", 64'(ready8), 64'd0);
                chk("async reset m", 64'(m8), 64'd0);
                @(negedge clk);
                @(negedge clk);
                #2 rst8 = 1'b1;
                @(negedge clk);
                op(0, 13, 11, 1'b0, 1'b0);
                op(0, 'h80, 'h80, 1'b1, 1'b1);
                for (int n = 0; n < 200; n++) begin
                    op(0, pick(8), pick(8), 1'($urandom_range(0, 1)), $urandom_range(0, 3) == 0);
                    if ($urandom_range(0, 1) == 1) @(negedge clk);
                end
            end
            begin
                for (int s = 0; s < 2; s++)
                    for (int n = 0; n < 1000; n++) begin
                        op(1, pick(16), pick(16), 1'(s), $urandom_range(0, 3) == 0);
                        if ($urandom_range(0, 1) == 1) @(negedge clk);
                    end
            end
            begin
                for (int s = 0; s < 2; s++)
                    for (int n = 0; n < 1000; n++) begin
                        op(2, pick(2), pick(2), 1'(s), $urandom_range(0, 3) == 0);
                        if ($urandom_range(0, 1) == 1) @(negedge clk);
                    end
            end
        join

        repeat (40) @(negedge clk);
        chk("w8 results outstanding", 64'(q8.size()), 64'd0);
        chk("w16 results outstanding", 64'(q16.size()), 64'd0);
        chk("w2 results outstanding", 64'(q2.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
